// File: rtl/data_mem_pkg.sv
// Shared types and elaboration helpers for the byte-enabled data memory.
package data_mem_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  function automatic int unsigned bytes(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic bit params_ok(input int unsigned data_width,
                                   input int unsigned read_latency);
    return (data_width != 0) && (data_width % 8 == 0) &&
           (read_latency == 1 || read_latency == 2);
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x DATA_WIDTH storage: byte-enable write, registered read, one access per edge.
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            write_en,
  input  logic                            read_en,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [DATA_WIDTH-1:0]           wdata,
  input  logic [bytes(DATA_WIDTH)-1:0]    be,
  output logic [DATA_WIDTH-1:0]           rdata
);

  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
  localparam int unsigned NBYTES = bytes(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage itself is never reset; only the read register is.
  always_ff @(posedge clock) begin
    if (write_en) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     rdata <= '0;
    else if (read_en) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: post-reset clear FSM, request arbitration, error pulse
// and optional second read stage around data_mem_array.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         mem_read,
  input  logic                         mem_write,
  input  logic [ADDR_WIDTH-1:0]        address,
  input  logic [DATA_WIDTH-1:0]        data_to_write,
  input  logic [bytes(DATA_WIDTH)-1:0] byte_en,
  output logic                         req_ready,
  output logic [DATA_WIDTH-1:0]        readed_data,
  output logic                         rvalid,
  output logic                         err,
  output logic                         busy
);

  localparam int unsigned NBYTES = bytes(DATA_WIDTH);

  if (!params_ok(DATA_WIDTH, READ_LATENCY)) begin : g_bad_params
    $error("data_mem_ctrl: DATA_WIDTH must be a multiple of 8, READ_LATENCY 1 or 2");
  end

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clear_addr;
  logic                    clearing;
  logic                    accept_rd;
  logic                    accept_wr;
  logic                    illegal;
  logic                    arr_we;
  logic [ADDR_WIDTH-1:0]   arr_addr;
  logic [DATA_WIDTH-1:0]   arr_wdata;
  logic [NBYTES-1:0]       arr_be;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    v1;

  assign clearing  = (state == CLEAR);
  assign busy      = clearing;
  assign accept_rd = req_ready & mem_read & ~mem_write;
  assign accept_wr = req_ready & mem_write & ~mem_read;
  assign illegal   = req_ready & mem_read & mem_write;

  // The clear sequence borrows the single array port, so it owns the mux while busy.
  assign arr_we    = clearing | accept_wr;
  assign arr_addr  = clearing ? clear_addr : address;
  assign arr_wdata = clearing ? '0 : data_to_write;
  assign arr_be    = clearing ? '1 : byte_en;

  // req_ready is registered so that it only rises on the edge that completes the clear
  // (or the first edge after reset when the clear is skipped).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clear_addr <= '0;
      req_ready  <= 1'b0;
      err        <= 1'b0;
      v1         <= 1'b0;
    end else begin
      err <= illegal;
      v1  <= accept_rd;
      case (state)
        CLEAR: begin
          clear_addr <= clear_addr + ADDR_WIDTH'(1);
          if (clear_addr == '1) begin
            state     <= READY;
            req_ready <= 1'b1;
          end
        end
        READY: req_ready <= 1'b1;
      endcase
    end
  end

  data_mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clock   (clock),
    .reset_n (reset_n),
    .write_en(arr_we),
    .read_en (accept_rd),
    .addr    (arr_addr),
    .wdata   (arr_wdata),
    .be      (arr_be),
    .rdata   (rdata)
  );

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  v2;
    logic [DATA_WIDTH-1:0] d2;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        if (v1) d2 <= rdata;
      end
    end

    assign rvalid      = v2;
    assign readed_data = d2;
  end else begin : g_lat1
    assign rvalid      = v1;
    assign readed_data = rdata;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: driver pushes expected responses, monitor pops on rvalid/err.
module tb_data_mem_ctrl;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned RL    = 2;
  localparam int unsigned NB    = DW / 8;
  localparam int unsigned DEPTH = 2 ** AW;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] data_to_write = '0;
  logic [NB-1:0] byte_en = '0;
  logic          req_ready;
  logic [DW-1:0] readed_data;
  logic          rvalid;
  logic          err;
  logic          busy;

  always #5 clock = ~clock;

  data_mem_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .READ_LATENCY(RL),
    .CLEAR_ON_RESET(1)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .address(address),
    .data_to_write(data_to_write),
    .byte_en(byte_en),
    .req_ready(req_ready),
    .readed_data(readed_data),
    .rvalid(rvalid),
    .err(err),
    .busy(busy)
  );

  typedef struct {
    int unsigned   due;
    logic [DW-1:0] data;
  } rd_exp_t;

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  int unsigned   cyc = 0;
  int unsigned   edges = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] last_data = '0;
  rd_exp_t       rd_q[$];
  int unsigned   err_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc++;

  // Edges since reset release; the block must be ready once DEPTH clear edges have passed.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) edges = 0;
    else          edges++;
  end

  initial begin : monitor
    rd_exp_t e;
    logic    exp_err;
    forever begin
      @(posedge clock);
      #1;
      if (reset_n) begin
        chk("req_ready", 32'(req_ready), 32'(edges >= DEPTH));
        chk("busy", 32'(busy), 32'(edges < DEPTH));
        if (rvalid) begin
          if (rd_q.size() == 0) begin
            chk("unexpected_rvalid", 32'(rvalid), 32'(0));
          end else begin
            e = rd_q.pop_front();
            chk("rvalid_cycle", cyc, e.due);
            chk("readed_data", 32'(readed_data), 32'(e.data));
            last_data = e.data;
          end
        end else begin
          if (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
            e = rd_q.pop_front();
            chk("missing_rvalid", 32'(rvalid), 32'(1));
          end
          chk("data_hold", 32'(readed_data), 32'(last_data));
        end
        exp_err = (err_q.size() != 0 && err_q[0] == cyc);
        if (exp_err) void'(err_q.pop_front());
        chk("err", 32'(err), 32'(exp_err));
      end
    end
  end

  task automatic issue(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [NB-1:0] be);
    rd_exp_t e;
    @(negedge clock);
    mem_read      = rd;
    mem_write     = wr;
    address       = a;
    data_to_write = d;
    byte_en       = be;
    if (reset_n && edges >= DEPTH) begin
      if (rd && wr) begin
        err_q.push_back(cyc + 1);
      end else if (rd) begin
        e.due  = cyc + RL;
        e.data = model[a];
        rd_q.push_back(e);
      end else if (wr) begin
        for (int i = 0; i < int'(NB); i++)
          if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
      end
    end
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic rand_req();
    int unsigned op;
    op = $urandom_range(0, 9);
    issue(op < 4 || op == 8, (op >= 4 && op < 8) || op == 8,
          AW'($urandom), DW'($urandom), NB'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clock);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reset_n   = 1'b0;
    #1;
    chk("rst_rvalid", 32'(rvalid), 32'(0));
    chk("rst_readed_data", 32'(readed_data), 32'(0));
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_busy", 32'(busy), 32'(1));
    chk("rst_err", 32'(err), 32'(0));
    rd_q.delete();
    err_q.delete();
    last_data = '0;
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin : stimulus
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    repeat (3) @(negedge clock);
    #1;
    chk("init_busy", 32'(busy), 32'(1));
    chk("init_req_ready", 32'(req_ready), 32'(0));
    chk("init_rvalid", 32'(rvalid), 32'(0));
    reset_n = 1'b1;

    // Requests during the clear must be ignored.
    repeat (DEPTH) rand_req();
    for (int a = 0; a < int'(DEPTH); a++) issue(1'b1, 1'b0, AW'(a), '0, '0);

    issue(1'b0, 1'b1, AW'(3), 16'hBEEF, 2'b11);
    issue(1'b0, 1'b1, AW'(3), 16'h0012, 2'b01);
    issue(1'b1, 1'b0, AW'(3), '0, '0);
    idle();

    for (int a = 0; a < 4; a++) issue(1'b0, 1'b1, AW'(a), DW'(16'h1111 * (a + 1)), 2'b11);
    for (int a = 0; a < 4; a++) issue(1'b1, 1'b0, AW'(a), '0, '0);
    idle();

    issue(1'b0, 1'b1, AW'(5), 16'h1357, 2'b11);
    issue(1'b1, 1'b1, AW'(5), 16'hAAAA, 2'b11);
    issue(1'b1, 1'b0, AW'(5), '0, '0);
    issue(1'b0, 1'b1, AW'(5), 16'hFFFF, 2'b00);
    issue(1'b1, 1'b0, AW'(5), '0, '0);

    issue(1'b0, 1'b1, AW'(7), 16'h5A5A, 2'b11);
    issue(1'b1, 1'b0, AW'(7), '0, '0);
    issue(1'b0, 1'b1, AW'(7), 16'h1234, 2'b11);
    issue(1'b1, 1'b0, AW'(7), '0, '0);
    issue(1'b0, 1'b1, AW'(7), 16'hCDEF, 2'b10);
    issue(1'b1, 1'b0, AW'(7), '0, '0);

    repeat (400) rand_req();

    issue(1'b0, 1'b1, AW'(1), 16'h7777, 2'b11);
    issue(1'b1, 1'b0, AW'(1), '0, '0);
    do_reset();
    repeat (DEPTH) idle();
    issue(1'b1, 1'b0, AW'(1), '0, '0);
    issue(1'b1, 1'b0, AW'(3), '0, '0);
    repeat (100) rand_req();

    repeat (RL + 3) idle();
    chk("rd_queue_drained", 32'(rd_q.size()), 32'(0));
    chk("err_queue_drained", 32'(err_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
